// File: rtl/nand_logic_pkg.sv
// Shared operation encodings for the nand-built logic pipeline.
package nand_logic_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/nand_bit_cell.sv
// One-bit logic cell: every data function is derived from 2-input nand gates,
// and only the final op select is behavioural.
module nand_bit_cell
  import nand_logic_pkg::*;
(
  input  logic            a,
  input  logic            b,
  input  logic [OP_W-1:0] op,
  output logic            y
);

  wire not_a, not_b, nand_ab, and_ab, or_ab, nor_ab;
  wire xor_t1, xor_t2, xor_ab, xnor_ab, pass_a;

  nand g_not_a   (not_a,   a,       a);
  nand g_not_b   (not_b,   b,       b);
  nand g_nand    (nand_ab, a,       b);
  nand g_and     (and_ab,  nand_ab, nand_ab);
  nand g_or      (or_ab,   not_a,   not_b);
  nand g_nor     (nor_ab,  or_ab,   or_ab);
  // Classic 4-nand xor shares the nand(a,b) term.
  nand g_xor_t1  (xor_t1,  a,       nand_ab);
  nand g_xor_t2  (xor_t2,  b,       nand_ab);
  nand g_xor     (xor_ab,  xor_t1,  xor_t2);
  nand g_xnor    (xnor_ab, xor_ab,  xor_ab);
  nand g_pass    (pass_a,  not_a,   not_a);

  always_comb begin
    y = pass_a;
    unique case (op)
      OP_AND:  y = and_ab;
      OP_OR:   y = or_ab;
      OP_NOT:  y = not_a;
      OP_NAND: y = nand_ab;
      OP_NOR:  y = nor_ab;
      OP_XOR:  y = xor_ab;
      OP_XNOR: y = xnor_ab;
      OP_PASS: y = pass_a;
      default: y = pass_a;
    endcase
  end

endmodule

// File: rtl/nand_logic_pipe.sv
// Vector nand-built logic unit feeding a STAGES-deep valid/ready pipeline with
// bubble collapse and a count of completed output handshakes.
module nand_logic_pipe
  import nand_logic_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [OP_W-1:0]  out_op,
  output logic [CNT_W-1:0] op_count
);

  logic [WIDTH-1:0]  y_comb;
  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] load;
  logic [WIDTH-1:0]  stage_y  [STAGES];
  logic [OP_W-1:0]   stage_op [STAGES];
  logic [CNT_W-1:0]  count_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    nand_bit_cell u_cell (
      .a  (in_a[i]),
      .b  (in_b[i]),
      .op (in_op),
      .y  (y_comb[i])
    );
  end

  // A stage may load when it is empty or its successor loads; walk from the output back.
  always_comb begin : load_chain
    logic adv;
    adv  = out_ready;
    load = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      adv     = !stage_valid[k] || adv;
      load[k] = adv;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_y;
    logic [OP_W-1:0]  up_op;
    logic             valid_q;
    logic [WIDTH-1:0] y_q;
    logic [OP_W-1:0]  op_q;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_y     = y_comb;
      assign up_op    = in_op;
    end else begin : g_body
      assign up_valid = stage_valid[k-1];
      assign up_y     = stage_y[k-1];
      assign up_op    = stage_op[k-1];
    end

    // Payload only moves with a valid token so idle operands never reach held stages.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        y_q     <= '0;
        op_q    <= '0;
      end else if (load[k]) begin
        valid_q <= up_valid;
        if (up_valid) begin
          y_q  <= up_y;
          op_q <= up_op;
        end
      end
    end

    assign stage_valid[k] = valid_q;
    assign stage_y[k]     = y_q;
    assign stage_op[k]    = op_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (out_valid && out_ready) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign in_ready  = load[0];
  assign out_valid = stage_valid[STAGES-1];
  assign out_y     = stage_y[STAGES-1];
  assign out_op    = stage_op[STAGES-1];
  assign op_count  = count_q;

endmodule
